// File: rtl/exu_fu_issue_if.sv
// Functional-unit request/response port shared by the ALU and later MUL/DIV units.
// The issuing side uses master, the functional unit uses slave.
interface exu_fu_issue_if #(
  parameter int OP_W = 5
);
  logic            fu_valid;
  logic [63:0]     fu_a;
  logic [63:0]     fu_b;
  logic [OP_W-1:0] fu_op;
  logic [63:0]     fu_data;
  logic            fu_data_ok;

  modport master (
    output fu_valid, fu_a, fu_b, fu_op,
    input  fu_data, fu_data_ok
  );

  modport slave (
    input  fu_valid, fu_a, fu_b, fu_op,
    output fu_data, fu_data_ok
  );
endinterface

// File: rtl/exu_fu_issue.sv
// Execute-stage FU initiator: takes one op from ID, holds it at the FU until data_ok
// (or timeout), then presents the captured result to writeback.
module exu_fu_issue #(
  parameter int OP_W    = 5,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [63:0]     in_a,
  input  logic [63:0]     in_b,
  input  logic [OP_W-1:0] in_op,
  input  logic [4:0]      in_rd,
  input  logic            in_wen,
  exu_fu_issue_if.master  fu,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [63:0]     out_data,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic            out_err,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t          state;
  state_t          state_nxt;
  logic [63:0]     a_q;
  logic [63:0]     b_q;
  logic [OP_W-1:0] op_q;
  logic [4:0]      rd_q;
  logic            wen_q;
  logic [63:0]     data_q;
  logic            err_q;
  logic [7:0]      req_cnt;
  logic [7:0]      req_cnt_nxt;
  logic            accept;
  logic            data_hit;
  logic            timeout_hit;

  assign in_ready = !flush && ((state == IDLE) || ((state == RESP) && out_ready));
  assign accept   = in_valid && in_ready;

  // data_ok in the first REQ cycle may be a leftover from the previous request
  assign data_hit    = (state == REQ) && fu.fu_data_ok && (req_cnt != 8'd0);
  assign req_cnt_nxt = (req_cnt == 8'hFF) ? req_cnt : req_cnt + 8'd1;
  assign timeout_hit = (state == REQ) && !data_hit && (req_cnt_nxt == TIMEOUT_CNT);

  assign fu.fu_valid = (state == REQ);
  assign fu.fu_a     = a_q;
  assign fu.fu_b     = b_q;
  assign fu.fu_op    = op_q;

  assign out_valid = (state == RESP);
  assign out_data  = data_q;
  assign out_rd    = rd_q;
  assign out_wen   = wen_q;
  assign out_err   = err_q;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = REQ;
      end
      REQ: begin
        if (data_hit || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        if (out_ready) state_nxt = accept ? REQ : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // flush beats everything, including a same-cycle FU result
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      req_cnt <= '0;
    end else if (accept) begin
      a_q     <= in_a;
      b_q     <= in_b;
      op_q    <= in_op;
      rd_q    <= in_rd;
      wen_q   <= in_wen;
      err_q   <= 1'b0;
      req_cnt <= '0;
    end else if ((state == REQ) && !flush) begin
      req_cnt <= req_cnt_nxt;
      if (data_hit) begin
        data_q <= fu.fu_data;
        err_q  <= 1'b0;
      end else if (timeout_hit) begin
        data_q <= '0;
        wen_q  <= 1'b0;
        err_q  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_exu_fu_issue.sv
// Randomized and directed bench for exu_fu_issue: a latency-driven FU responder plus a
// transaction model that predicts handshake timing and results from the chosen FU latency.
module tb_exu_fu_issue;

  localparam int OP_W    = 5;
  localparam int TIMEOUT = 16;

  logic            clk       = 1'b0;
  logic            resetn    = 1'b0;
  logic            flush     = 1'b0;
  logic            in_valid  = 1'b0;
  logic [63:0]     in_a      = '0;
  logic [63:0]     in_b      = '0;
  logic [OP_W-1:0] in_op     = '0;
  logic [4:0]      in_rd     = '0;
  logic            in_wen    = 1'b0;
  logic            out_ready = 1'b0;
  logic            in_ready;
  logic            out_valid;
  logic [63:0]     out_data;
  logic [4:0]      out_rd;
  logic            out_wen;
  logic            out_err;
  logic            busy;

  exu_fu_issue_if #(.OP_W(OP_W)) fu_if ();

  exu_fu_issue #(.OP_W(OP_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_wen    (in_wen),
    .fu        (fu_if.master),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rd    (out_rd),
    .out_wen   (out_wen),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]     a;
    logic [63:0]     b;
    logic [OP_W-1:0] op;
    logic [4:0]      rd;
    logic            wen;
    int              acc_cycle;
  } op_t;

  op_t op_q[$];
  int  lat_q[$];
  int  cyc            = 0;
  int  last_acc_cycle = -1;
  int  last_ret_cycle = -1;
  int  checks         = 0;
  int  failures       = 0;

  bit  rand_lat     = 1'b0;
  int  fix_lat      = 1;
  int  stale_cycles = 0;
  bit  active       = 1'b0;
  int  k            = 0;
  int  cur_lat      = 0;
  int  stale_left   = 0;

  bit  holding;
  bit  resp_exp;
  bit  req_exp;
  bit  rdy_exp;
  bit  exp_err;
  op_t new_op;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] fu_func(input logic [63:0] a, input logic [63:0] b,
                                          input logic [OP_W-1:0] op);
    return a + b + 64'(op);
  endfunction

  function automatic int pick_lat();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return TIMEOUT;
    if (r == 1) return TIMEOUT - 1;
    if (r == 2) return 30;
    return int'($urandom_range(1, 4));
  endfunction

  // FU responder: answers each request after its chosen latency, optionally leaving data_ok up afterwards
  always @(posedge clk) begin
    #1;
    if (!resetn) begin
      active           = 1'b0;
      stale_left       = 0;
      fu_if.fu_data_ok = 1'b0;
      fu_if.fu_data    = '0;
    end else if (fu_if.fu_valid) begin
      if (!active) begin
        active  = 1'b1;
        k       = 0;
        cur_lat = rand_lat ? pick_lat() : fix_lat;
        lat_q.push_back(cur_lat);
      end else begin
        k++;
      end
      if (k != 0 && k >= cur_lat) begin
        fu_if.fu_data_ok = 1'b1;
        fu_if.fu_data    = fu_func(fu_if.fu_a, fu_if.fu_b, fu_if.fu_op);
      end else if (stale_left > 0) begin
        stale_left--;
        fu_if.fu_data_ok = 1'b1;
      end else begin
        fu_if.fu_data_ok = 1'b0;
        fu_if.fu_data    = {$urandom, $urandom};
      end
    end else begin
      if (active) begin
        active     = 1'b0;
        stale_left = (k >= cur_lat) ? stale_cycles : 0;
      end
      if (stale_left > 0) begin
        stale_left--;
        fu_if.fu_data_ok = 1'b1;
      end else begin
        fu_if.fu_data_ok = 1'b0;
        fu_if.fu_data    = {$urandom, $urandom};
      end
    end
  end

  // Transaction model: an op becomes a result lat+2 cycles after accept (capped by the timeout)
  always @(negedge clk) begin
    cyc++;
    if (!resetn) begin
      op_q.delete();
      lat_q.delete();
    end else begin
      holding  = (op_q.size() != 0);
      resp_exp = 1'b0;
      if (holding && lat_q.size() != 0)
        resp_exp = (cyc >= op_q[0].acc_cycle + 2 +
                    ((lat_q[0] < TIMEOUT) ? lat_q[0] : TIMEOUT - 1));
      req_exp = holding && !resp_exp;
      rdy_exp = !flush && (!holding || (resp_exp && out_ready));

      checkOutput("in_ready", 64'(in_ready), 64'(rdy_exp));
      checkOutput("busy", 64'(busy), 64'(holding));
      checkOutput("fu_valid", 64'(fu_if.fu_valid), 64'(req_exp));
      checkOutput("out_valid", 64'(out_valid), 64'(resp_exp));
      if (req_exp) begin
        checkOutput("fu_a", fu_if.fu_a, op_q[0].a);
        checkOutput("fu_b", fu_if.fu_b, op_q[0].b);
        checkOutput("fu_op", 64'(fu_if.fu_op), 64'(op_q[0].op));
      end
      if (resp_exp) begin
        exp_err = (lat_q[0] >= TIMEOUT);
        checkOutput("out_data", out_data,
                    exp_err ? 64'd0 : fu_func(op_q[0].a, op_q[0].b, op_q[0].op));
        checkOutput("out_rd", 64'(out_rd), 64'(op_q[0].rd));
        checkOutput("out_wen", 64'(out_wen), exp_err ? 64'd0 : 64'(op_q[0].wen));
        checkOutput("out_err", 64'(out_err), 64'(exp_err));
      end

      if (resp_exp && out_ready) begin
        void'(op_q.pop_front());
        void'(lat_q.pop_front());
        last_ret_cycle = cyc;
      end
      if (flush) begin
        op_q.delete();
        lat_q.delete();
      end
      if (in_valid && rdy_exp) begin
        new_op.a         = in_a;
        new_op.b         = in_b;
        new_op.op        = in_op;
        new_op.rd        = in_rd;
        new_op.wen       = in_wen;
        new_op.acc_cycle = cyc;
        op_q.push_back(new_op);
        last_acc_cycle = cyc;
      end
    end
  end

  // Offers one op and returns at posedge+1 of the cycle after it is accepted
  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                               input logic [OP_W-1:0] op, input logic [4:0] rd, input logic wen);
    bit done;
    done     = 1'b0;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_rd    = rd;
    in_wen   = wen;
    in_valid = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      #1;
      if (last_acc_cycle == cyc) done = 1'b1;
    end
    if (!done) checkOutput("accept_wait", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitOutValid(input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    if (!seen) checkOutput("out_valid_wait", 64'd0, 64'd1);
  endtask

  int acc1;

  initial begin
    #7;
    checkOutput("rst_fu_valid", 64'(fu_if.fu_valid), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_out_err", 64'(out_err), 64'd0);
    checkOutput("rst_out_data", out_data, 64'd0);
    checkOutput("rst_out_wen", 64'(out_wen), 64'd0);
    checkOutput("rst_fu_a", fu_if.fu_a, 64'd0);
    #15;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single op");
    fix_lat = 1; stale_cycles = 0; out_ready = 1'b1;
    applyStimulus(64'd5, 64'd7, 5'd0, 5'd3, 1'b1);
    acc1 = last_acc_cycle;
    waitOutValid(10);
    checkOutput("single_latency", 64'(cyc - acc1), 64'd3);
    checkOutput("single_data", out_data, 64'd12);
    checkOutput("single_rd", 64'(out_rd), 64'd3);
    checkOutput("single_wen", 64'(out_wen), 64'd1);
    checkOutput("single_err", 64'(out_err), 64'd0);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] back-to-back with stale data_ok");
    stale_cycles = 2;
    applyStimulus(64'd100, 64'd23, 5'd1, 5'd4, 1'b1);
    acc1 = last_acc_cycle;
    applyStimulus(64'd1000, 64'd1, 5'd2, 5'd5, 1'b1);
    checkOutput("b2b_accept_gap", 64'(last_acc_cycle - acc1), 64'd3);
    checkOutput("b2b_same_cycle", 64'(last_ret_cycle), 64'(last_acc_cycle));
    acc1 = last_acc_cycle;
    waitOutValid(10);
    checkOutput("b2b_latency", 64'(cyc - acc1), 64'd3);
    checkOutput("b2b_data", out_data, 64'd1003);
    repeat (3) @(posedge clk);
    #1;
    stale_cycles = 0;

    $display("[TB] backpressure");
    fix_lat = 2; out_ready = 1'b0;
    applyStimulus(64'd40, 64'd2, 5'd0, 5'd9, 1'b1);
    waitOutValid(10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checkOutput("bp_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_data", out_data, 64'd42);
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
      checkOutput("bp_fu_valid", 64'(fu_if.fu_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release", 64'(out_valid), 64'd0);

    $display("[TB] timeout");
    fix_lat = 100;
    applyStimulus(64'd9, 64'd9, 5'd3, 5'd7, 1'b1);
    acc1 = last_acc_cycle;
    waitOutValid(40);
    checkOutput("to_latency", 64'(cyc - acc1), 64'(TIMEOUT + 1));
    checkOutput("to_err", 64'(out_err), 64'd1);
    checkOutput("to_data", out_data, 64'd0);
    checkOutput("to_wen", 64'(out_wen), 64'd0);
    checkOutput("to_rd", 64'(out_rd), 64'd7);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] flush with data_ok");
    fix_lat = 1;
    applyStimulus(64'd11, 64'd22, 5'd4, 5'd2, 1'b1);
    acc1 = last_acc_cycle;
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    applyStimulus(64'd3, 64'd4, 5'd0, 5'd6, 1'b0);
    checkOutput("flush_next_accept", 64'(last_acc_cycle - acc1), 64'd3);
    waitOutValid(10);
    checkOutput("flush_next_data", out_data, 64'd7);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] random traffic");
    rand_lat = 1'b1;
    for (int i = 0; i < 800; i++) begin
      in_valid     = 1'($urandom_range(0, 1));
      in_a         = {$urandom, $urandom};
      in_b         = {$urandom, $urandom};
      in_op        = OP_W'($urandom);
      in_rd        = 5'($urandom);
      in_wen       = 1'($urandom);
      out_ready    = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 39) == 0);
      stale_cycles = int'($urandom_range(0, 2));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; stale_cycles = 0;
    rand_lat = 1'b0; fix_lat = 5;
    repeat (40) @(posedge clk);
    #1;

    $display("[TB] async reset mid-REQ");
    applyStimulus(64'd8, 64'd8, 5'd1, 5'd1, 1'b1);
    @(posedge clk);
    #3;
    checkOutput("pre_rst_busy", 64'(busy), 64'd1);
    resetn = 1'b0;
    #1;
    checkOutput("arst_fu_valid", 64'(fu_if.fu_valid), 64'd0);
    checkOutput("arst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("arst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    #2;
    resetn = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("arst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exu_fu_issue.md
Name: exu_fu_issue

Overview:
- Initiator side of the execute-stage functional-unit handshake: `fu_valid` + operands/op out, `fu_data` + `fu_data_ok` back.
- Accepts one decoded operation from ID with a valid/ready handshake and holds operands and op stable at the FU until `fu_data_ok`.
- Captures the result and presents it to writeback with a valid/ready handshake.
- Sits between the ID/EX pipeline register and the ALU; a later MUL/DIV unit uses the same port.

Parameters:
- OP_W, 5, functional-unit opcode width (matches ALU opcode field).
- TIMEOUT, 16, max cycles in REQ before forced error completion; 2..255.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous pipeline flush; drops any in-flight op.
- in_valid  in  1  ID offers an operation.
- in_ready  out  1  block accepts operation this cycle.
- in_a  in  64  operand A.
- in_b  in  64  operand B.
- in_op  in  OP_W  opcode.
- in_rd  in  5  destination register.
- in_wen  in  1  register write enable.
- fu_valid  out  1  request to FU.
- fu_a  out  64  held operand A.
- fu_b  out  64  held operand B.
- fu_op  out  OP_W  held opcode.
- fu_data  in  64  FU result.
- fu_data_ok  in  1  FU result valid.
- out_valid  out  1  result available to WB.
- out_ready  in  1  WB accepts result.
- out_data  out  64  captured result (0 on timeout).
- out_rd  out  5  destination register.
- out_wen  out  1  write enable (forced 0 on timeout).
- out_err  out  1  result produced by timeout.
- busy  out  1  state != IDLE.

Behaviour:
- States:
  - IDLE: no operation held.
  - REQ: request outstanding at FU.
  - RESP: result held for WB.
- Reset (resetn low, async): state=IDLE; operand, result, rd, wen, err and counter registers = 0; fu_valid=0; out_valid=0; out_err=0; busy=0.
- Accept:
  - in_ready = !flush && (state==IDLE || (state==RESP && out_ready)).
  - in_valid && in_ready latches in_a, in_b, in_op, in_rd, in_wen; next state REQ; req_cnt cleared to 0.
- REQ:
  - fu_valid=1; fu_a, fu_b, fu_op driven from latched registers, constant for the whole REQ.
  - req_cnt increments each cycle, saturating.
  - fu_data_ok is honoured only when req_cnt != 0. The first REQ cycle is ignored because the FU minimum latency is 1 and a stale data_ok may linger one cycle after a prior request.
  - Honoured fu_data_ok: capture fu_data into out_data; out_err=0; next RESP.
  - Timeout: req_cnt reaches TIMEOUT with no honoured data_ok -> out_data=0, out_wen=0, out_err=1; next RESP.
- RESP:
  - out_valid=1; fu_valid=0; out_* held stable until out_valid && out_ready.
  - On handshake with a same-cycle accept -> REQ (back-to-back, no bubble).
  - On handshake without accept -> IDLE.
  - fu_data_ok is ignored in IDLE and RESP.
- Latency:
  - Accept at cycle t, REQ from t+1, FU with 1-cycle data_ok -> capture at end of t+2, out_valid at t+3.
  - Sustained throughput: one op per 3 cycles with a 1-cycle FU.
- Flush (synchronous, highest priority):
  - Any state -> IDLE next cycle; out_valid and fu_valid drop the next cycle.
  - Held result discarded; in_ready=0 during the flush cycle, so no accept.
- Simultaneous flush and honoured fu_data_ok: flush wins; result not presented.
- Reset mid-REQ or mid-RESP: immediate return to reset values; no output glitch held past reset deassertion.
- Widths: all datapath 64-bit pass-through; no arithmetic besides the 8-bit req_cnt.

Test Plan:
- Single op: in_a=5, in_b=7, in_op=0 (add), in_rd=3, in_wen=1; FU model asserts data_ok one cycle after fu_valid with fu_data=12 -> out_valid at t+3, out_data=12, out_rd=3, out_wen=1, out_err=0; fu_a/fu_b stable throughout REQ.
- Back-to-back with stale data_ok: two ops, out_ready=1, second offered during RESP; FU holds data_ok high one extra cycle after fu_valid falls -> second accepted in the same cycle as the first retires; stale data_ok in the second op's first REQ cycle ignored; second result equals the FU value for the second operands.
- Backpressure: out_ready=0 for 5 cycles in RESP -> out_valid stays 1, out_data unchanged, in_ready=0, fu_valid=0; release -> retires in 1 cycle.
- Timeout: FU never asserts data_ok, TIMEOUT=16 -> RESP after 16 REQ cycles with out_err=1, out_data=0, out_wen=0.
- Flush: flush in the second REQ cycle coinciding with fu_data_ok -> next cycle IDLE, out_valid never 1, busy=0; new op accepted the cycle after.
- Async reset: deassert resetn mid-REQ between clock edges -> fu_valid, out_valid and busy go 0 immediately; after release in_ready=1.
